// File: rtl/capop_pkg.sv
// rtl/capop_pkg.sv - shared widths, op/fault codes and capability record for the capop engine
package capop_pkg;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 24;
  localparam int CR_W   = 2;
  localparam int OP_W   = 3;
  localparam int FLT_W  = 3;
  localparam int EN_W   = 6;

  localparam logic [OP_W-1:0] CAPOP_CMOV    = 3'd0;
  localparam logic [OP_W-1:0] CAPOP_CINC    = 3'd1;
  localparam logic [OP_W-1:0] CAPOP_CSETB   = 3'd2;
  localparam logic [OP_W-1:0] CAPOP_CANDP   = 3'd3;
  localparam logic [OP_W-1:0] CAPOP_CSEAL   = 3'd4;
  localparam logic [OP_W-1:0] CAPOP_CUNSEAL = 3'd5;
  localparam logic [OP_W-1:0] CAPOP_CCLRTAG = 3'd6;

  localparam logic [FLT_W-1:0] CAPFLT_NONE    = 3'd0;
  localparam logic [FLT_W-1:0] CAPFLT_TAG     = 3'd1;
  localparam logic [FLT_W-1:0] CAPFLT_SEALED  = 3'd2;
  localparam logic [FLT_W-1:0] CAPFLT_BOUNDS  = 3'd3;
  localparam logic [FLT_W-1:0] CAPFLT_OTYPE   = 3'd4;
  localparam logic [FLT_W-1:0] CAPFLT_ILLEGAL = 3'd5;

  localparam int CR_ATTR_SEALED_BIT = 0;
  localparam int CR_ATTR_OTYPE_LSB  = 8;
  localparam int CR_ATTR_OTYPE_MSB  = 23;

  // Bit positions of the per-field write-enable vector.
  localparam int EN_BASE  = 0;
  localparam int EN_LEN   = 1;
  localparam int EN_CUR   = 2;
  localparam int EN_PERMS = 3;
  localparam int EN_ATTR  = 4;
  localparam int EN_TAG   = 5;

  localparam logic [EN_W-1:0] EN_NONE     = 6'b000000;
  localparam logic [EN_W-1:0] EN_ALL      = 6'b111111;
  localparam logic [EN_W-1:0] EN_M_PERMS  = 6'b001000;
  localparam logic [EN_W-1:0] EN_M_ATTR   = 6'b010000;
  localparam logic [EN_W-1:0] EN_M_TAG    = 6'b100000;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cur;
    logic [DATA_W-1:0] perms;
    logic [DATA_W-1:0] attr;
    logic              tag;
  } cap_t;

  function automatic logic cap_sealed(input cap_t c);
    return c.attr[CR_ATTR_SEALED_BIT];
  endfunction

  function automatic logic [15:0] cap_otype(input cap_t c);
    return c.attr[CR_ATTR_OTYPE_MSB:CR_ATTR_OTYPE_LSB];
  endfunction

endpackage

// File: rtl/capop_alu.sv
// rtl/capop_alu.sv - combinational validation and result computation for one capability op
module capop_alu
  import capop_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] imm,
  input  cap_t              src,
  output cap_t              result,
  output logic [EN_W-1:0]   wr_en,
  output logic [FLT_W-1:0]  fault
);

  logic            sealed;
  logic            tag_exempt;
  logic            otype_match;
  logic [ADDR_W:0] new_end;
  logic [ADDR_W:0] limit;
  logic            in_bounds;

  assign sealed      = cap_sealed(src);
  assign tag_exempt  = (op == CAPOP_CMOV) || (op == CAPOP_CCLRTAG);
  assign otype_match = (cap_otype(src) == imm[15:0]);

  // One extra bit so cur+imm and base+len cannot wrap during the bounds test.
  assign new_end   = {1'b0, src.cur} + {1'b0, imm};
  assign limit     = {1'b0, src.base} + {1'b0, src.len};
  assign in_bounds = (src.cur >= src.base) && (new_end <= limit);

  always_comb begin
    result = src;
    wr_en  = EN_NONE;
    fault  = CAPFLT_NONE;

    case (op)
      CAPOP_CMOV: begin
        wr_en = EN_ALL;
      end
      CAPOP_CINC: begin
        if (sealed) begin
          fault = CAPFLT_SEALED;
        end else begin
          result.cur = src.cur + imm;
          wr_en      = EN_ALL;
        end
      end
      CAPOP_CSETB: begin
        if (sealed) begin
          fault = CAPFLT_SEALED;
        end else if (!in_bounds) begin
          fault = CAPFLT_BOUNDS;
        end else begin
          result.base = src.cur;
          result.cur  = src.cur;
          result.len  = imm;
          wr_en       = EN_ALL;
        end
      end
      CAPOP_CANDP: begin
        if (sealed) begin
          fault = CAPFLT_SEALED;
        end else begin
          result.perms = src.perms & imm[DATA_W-1:0];
          wr_en        = EN_M_PERMS;
        end
      end
      CAPOP_CSEAL: begin
        if (sealed) begin
          fault = CAPFLT_SEALED;
        end else begin
          result.attr = {imm[15:0], 7'b0, 1'b1};
          wr_en       = EN_M_ATTR;
        end
      end
      CAPOP_CUNSEAL: begin
        if (!sealed || !otype_match) begin
          fault = CAPFLT_OTYPE;
        end else begin
          result.attr = '0;
          wr_en       = EN_M_ATTR;
        end
      end
      CAPOP_CCLRTAG: begin
        result.tag = 1'b0;
        wr_en      = EN_M_TAG;
      end
      default: begin
        fault = CAPFLT_ILLEGAL;
      end
    endcase

    // An untagged source overrides every other outcome.
    if (!src.tag && !tag_exempt) begin
      fault = CAPFLT_TAG;
    end
    if (fault != CAPFLT_NONE) begin
      wr_en = EN_NONE;
    end
  end

endmodule

// File: rtl/capop_unit.sv
// rtl/capop_unit.sv - four-state capability-op engine between issue and the CR0..CR3 register file
module capop_unit
  import capop_pkg::*;
(
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_req_valid,
  output logic              ow_req_ready,
  input  logic [OP_W-1:0]   iw_op,
  input  logic [CR_W-1:0]   iw_src_cr,
  input  logic [CR_W-1:0]   iw_dst_cr,
  input  logic [ADDR_W-1:0] iw_imm,
  output logic [CR_W-1:0]   ow_rd_addr,
  input  logic [ADDR_W-1:0] iw_rd_base,
  input  logic [ADDR_W-1:0] iw_rd_len,
  input  logic [ADDR_W-1:0] iw_rd_cur,
  input  logic [DATA_W-1:0] iw_rd_perms,
  input  logic [DATA_W-1:0] iw_rd_attr,
  input  logic              iw_rd_tag,
  output logic [CR_W-1:0]   ow_wr_addr,
  output logic              ow_wr_en_base,
  output logic              ow_wr_en_len,
  output logic              ow_wr_en_cur,
  output logic              ow_wr_en_perms,
  output logic              ow_wr_en_attr,
  output logic              ow_wr_en_tag,
  output logic [ADDR_W-1:0] ow_wr_base,
  output logic [ADDR_W-1:0] ow_wr_len,
  output logic [ADDR_W-1:0] ow_wr_cur,
  output logic [DATA_W-1:0] ow_wr_perms,
  output logic [DATA_W-1:0] ow_wr_attr,
  output logic              ow_wr_tag,
  output logic              ow_done,
  output logic [FLT_W-1:0]  ow_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  logic [OP_W-1:0]   op_q;
  logic [CR_W-1:0]   src_q;
  logic [CR_W-1:0]   dst_q;
  logic [ADDR_W-1:0] imm_q;
  cap_t              rd_cap;
  cap_t              src_cap_q;
  cap_t              alu_res;
  logic [EN_W-1:0]   alu_en;
  logic [FLT_W-1:0]  alu_fault;
  cap_t              res_q;
  logic [EN_W-1:0]   en_q;
  logic [FLT_W-1:0]  fault_q;
  logic [EN_W-1:0]   wr_en;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (iw_req_valid) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_cap.base  = iw_rd_base;
  assign rd_cap.len   = iw_rd_len;
  assign rd_cap.cur   = iw_rd_cur;
  assign rd_cap.perms = iw_rd_perms;
  assign rd_cap.attr  = iw_rd_attr;
  assign rd_cap.tag   = iw_rd_tag;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      op_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      src_cap_q <= '0;
      res_q     <= '0;
      en_q      <= EN_NONE;
      fault_q   <= CAPFLT_NONE;
    end else begin
      if (accept) begin
        op_q  <= iw_op;
        src_q <= iw_src_cr;
        dst_q <= iw_dst_cr;
        imm_q <= iw_imm;
      end
      if (state == S_READ) begin
        src_cap_q <= rd_cap;
      end
      if (state == S_EXEC) begin
        res_q   <= alu_res;
        en_q    <= alu_en;
        fault_q <= alu_fault;
      end
    end
  end

  capop_alu u_alu (
    .op     (op_q),
    .imm    (imm_q),
    .src    (src_cap_q),
    .result (alu_res),
    .wr_en  (alu_en),
    .fault  (alu_fault)
  );

  assign ow_req_ready = (state == S_IDLE);
  assign ow_rd_addr   = src_q;
  assign ow_wr_addr   = dst_q;
  assign ow_done      = (state == S_WRITE);
  assign ow_fault     = ow_done ? fault_q : CAPFLT_NONE;

  // Enables only escape during the single WRITE cycle.
  assign wr_en = ow_done ? en_q : EN_NONE;

  assign ow_wr_en_base  = wr_en[EN_BASE];
  assign ow_wr_en_len   = wr_en[EN_LEN];
  assign ow_wr_en_cur   = wr_en[EN_CUR];
  assign ow_wr_en_perms = wr_en[EN_PERMS];
  assign ow_wr_en_attr  = wr_en[EN_ATTR];
  assign ow_wr_en_tag   = wr_en[EN_TAG];

  assign ow_wr_base  = res_q.base;
  assign ow_wr_len   = res_q.len;
  assign ow_wr_cur   = res_q.cur;
  assign ow_wr_perms = res_q.perms;
  assign ow_wr_attr  = res_q.attr;
  assign ow_wr_tag   = res_q.tag;

endmodule

// File: tb/tb_capop_unit.sv
// tb/tb_capop_unit.sv - scoreboard bench for capop_unit with a behavioural register file
module tb_capop_unit;
  import capop_pkg::*;

  logic        iw_clk = 1'b0;
  logic        iw_rst = 1'b1;
  logic        iw_req_valid = 1'b0;
  logic        ow_req_ready;
  logic [2:0]  iw_op = '0;
  logic [1:0]  iw_src_cr = '0;
  logic [1:0]  iw_dst_cr = '0;
  logic [47:0] iw_imm = '0;
  logic [1:0]  ow_rd_addr;
  logic [47:0] iw_rd_base, iw_rd_len, iw_rd_cur;
  logic [23:0] iw_rd_perms, iw_rd_attr;
  logic        iw_rd_tag;
  logic [1:0]  ow_wr_addr;
  logic        ow_wr_en_base, ow_wr_en_len, ow_wr_en_cur;
  logic        ow_wr_en_perms, ow_wr_en_attr, ow_wr_en_tag;
  logic [47:0] ow_wr_base, ow_wr_len, ow_wr_cur;
  logic [23:0] ow_wr_perms, ow_wr_attr;
  logic        ow_wr_tag;
  logic        ow_done;
  logic [2:0]  ow_fault;

  typedef struct {
    logic [1:0]  addr;
    logic [5:0]  en;     // {tag, attr, perms, cur, len, base}
    cap_t        val;
    logic [2:0]  fault;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  cap_t rf[4];
  cap_t ref_rf[4];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic [2:0] last_fault = '0;
  logic [5:0] last_en = '0;
  logic       pl_en = 1'b0;
  logic [1:0] pl_idx = '0;
  cap_t       pl_val = '0;

  always #5 iw_clk = ~iw_clk;

  capop_unit dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_req_valid(iw_req_valid), .ow_req_ready(ow_req_ready),
    .iw_op(iw_op), .iw_src_cr(iw_src_cr), .iw_dst_cr(iw_dst_cr), .iw_imm(iw_imm),
    .ow_rd_addr(ow_rd_addr), .iw_rd_base(iw_rd_base), .iw_rd_len(iw_rd_len), .iw_rd_cur(iw_rd_cur),
    .iw_rd_perms(iw_rd_perms), .iw_rd_attr(iw_rd_attr), .iw_rd_tag(iw_rd_tag),
    .ow_wr_addr(ow_wr_addr), .ow_wr_en_base(ow_wr_en_base), .ow_wr_en_len(ow_wr_en_len),
    .ow_wr_en_cur(ow_wr_en_cur), .ow_wr_en_perms(ow_wr_en_perms), .ow_wr_en_attr(ow_wr_en_attr),
    .ow_wr_en_tag(ow_wr_en_tag), .ow_wr_base(ow_wr_base), .ow_wr_len(ow_wr_len), .ow_wr_cur(ow_wr_cur),
    .ow_wr_perms(ow_wr_perms), .ow_wr_attr(ow_wr_attr), .ow_wr_tag(ow_wr_tag),
    .ow_done(ow_done), .ow_fault(ow_fault)
  );

  assign iw_rd_base  = rf[ow_rd_addr].base;
  assign iw_rd_len   = rf[ow_rd_addr].len;
  assign iw_rd_cur   = rf[ow_rd_addr].cur;
  assign iw_rd_perms = rf[ow_rd_addr].perms;
  assign iw_rd_attr  = rf[ow_rd_addr].attr;
  assign iw_rd_tag   = rf[ow_rd_addr].tag;

  always @(posedge iw_clk) begin
    cyc <= cyc + 1;
    if (ow_wr_en_base)  rf[ow_wr_addr].base  <= ow_wr_base;
    if (ow_wr_en_len)   rf[ow_wr_addr].len   <= ow_wr_len;
    if (ow_wr_en_cur)   rf[ow_wr_addr].cur   <= ow_wr_cur;
    if (ow_wr_en_perms) rf[ow_wr_addr].perms <= ow_wr_perms;
    if (ow_wr_en_attr)  rf[ow_wr_addr].attr  <= ow_wr_attr;
    if (ow_wr_en_tag)   rf[ow_wr_addr].tag   <= ow_wr_tag;
    if (pl_en)          rf[pl_idx]           <= pl_val;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_cap(input string name, input cap_t act, input cap_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the architectural effect of one op on a source capability.
  function automatic exp_t model(input logic [2:0] op, input logic [47:0] imm, input cap_t s);
    exp_t e;
    longint unsigned cur, base, len, im;
    bit sealed;
    e.val = s; e.en = 6'b0; e.fault = 3'd0; e.addr = 2'd0; e.acc_cyc = 0;
    sealed = s.attr[0];
    cur = 64'(s.cur); base = 64'(s.base); len = 64'(s.len); im = 64'(imm);
    if (!s.tag && op != 3'd0 && op != 3'd6) begin
      e.fault = 3'd1;
    end else begin
      case (op)
        3'd0: e.en = 6'b111111;
        3'd1: if (sealed) e.fault = 3'd2;
              else begin e.val.cur = 48'((cur + im) % (64'd1 << 48)); e.en = 6'b111111; end
        3'd2: if (sealed) e.fault = 3'd2;
              else if (cur < base || cur + im > base + len) e.fault = 3'd3;
              else begin e.val.base = s.cur; e.val.cur = s.cur; e.val.len = imm; e.en = 6'b111111; end
        3'd3: if (sealed) e.fault = 3'd2;
              else begin e.val.perms = s.perms & imm[23:0]; e.en = 6'b001000; end
        3'd4: if (sealed) e.fault = 3'd2;
              else begin e.val.attr = 24'(imm[15:0]) * 24'd256 + 24'd1; e.en = 6'b010000; end
        3'd5: if (!sealed || s.attr[23:8] != imm[15:0]) e.fault = 3'd4;
              else begin e.val.attr = 24'd0; e.en = 6'b010000; end
        3'd6: begin e.val.tag = 1'b0; e.en = 6'b100000; end
        default: e.fault = 3'd5;
      endcase
    end
    return e;
  endfunction

  task automatic apply_ref(input exp_t e);
    if (e.en[0]) ref_rf[e.addr].base  = e.val.base;
    if (e.en[1]) ref_rf[e.addr].len   = e.val.len;
    if (e.en[2]) ref_rf[e.addr].cur   = e.val.cur;
    if (e.en[3]) ref_rf[e.addr].perms = e.val.perms;
    if (e.en[4]) ref_rf[e.addr].attr  = e.val.attr;
    if (e.en[5]) ref_rf[e.addr].tag   = e.val.tag;
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge iw_clk) begin
    logic [5:0] act_en;
    exp_t e;
    act_en = {ow_wr_en_tag, ow_wr_en_attr, ow_wr_en_perms, ow_wr_en_cur, ow_wr_en_len, ow_wr_en_base};
    if (!iw_rst) begin
      if (ow_done) begin
        last_fault = ow_fault;
        last_en = act_en;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(ow_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fault", 64'(ow_fault), 64'(e.fault));
          chk("enables", 64'(act_en), 64'(e.en));
          chk("wr_addr", 64'(ow_wr_addr), 64'(e.addr));
          chk("latency", 64'(cyc), 64'(e.acc_cyc + 3));
          chk("ready_in_write", 64'(ow_req_ready), 64'd0);
          if (e.en[0]) chk("wr_base", 64'(ow_wr_base), 64'(e.val.base));
          if (e.en[1]) chk("wr_len", 64'(ow_wr_len), 64'(e.val.len));
          if (e.en[2]) chk("wr_cur", 64'(ow_wr_cur), 64'(e.val.cur));
          if (e.en[3]) chk("wr_perms", 64'(ow_wr_perms), 64'(e.val.perms));
          if (e.en[4]) chk("wr_attr", 64'(ow_wr_attr), 64'(e.val.attr));
          if (e.en[5]) chk("wr_tag", 64'(ow_wr_tag), 64'(e.val.tag));
        end
      end else begin
        chk("stray_enable", 64'(act_en), 64'd0);
      end
    end
  end

  task automatic preload(input logic [1:0] idx, input cap_t c);
    pl_en = 1'b1; pl_idx = idx; pl_val = c;
    ref_rf[idx] = c;
    @(negedge iw_clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] s, input logic [1:0] d,
                       input logic [47:0] imm, input bit hold);
    exp_t e;
    int t;
    iw_req_valid = 1'b1; iw_op = op; iw_src_cr = s; iw_dst_cr = d; iw_imm = imm;
    t = 0;
    while (!ow_req_ready && t < 20) begin
      @(negedge iw_clk);
      t++;
    end
    if (!ow_req_ready) begin
      chk("accept_timeout", 64'(ow_req_ready), 64'd1);
      iw_req_valid = 1'b0;
    end else begin
      e = model(op, imm, ref_rf[s]);
      e.addr = d;
      e.acc_cyc = cyc;
      apply_ref(e);
      exp_q.push_back(e);
      @(negedge iw_clk);
      if (!hold) iw_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    iw_req_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge iw_clk);
      t++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge iw_clk);
  endtask

  function automatic cap_t mk_cap(input logic [47:0] b, input logic [47:0] l, input logic [47:0] c,
                                  input logic [23:0] a, input logic t);
    cap_t x;
    x.base = b; x.len = l; x.cur = c; x.perms = 24'h00F0F3; x.attr = a; x.tag = t;
    return x;
  endfunction

  function automatic cap_t rand_cap();
    cap_t c;
    c.base  = 48'($urandom_range(0, 32'h10000));
    c.len   = 48'($urandom_range(0, 32'h1000));
    c.cur   = c.base + 48'($urandom_range(0, 32'h1020)) - 48'h10;
    c.perms = 24'($urandom);
    c.attr  = 24'($urandom);
    if ($urandom_range(0, 1) == 0) c.attr[0] = 1'b0;
    c.tag   = ($urandom_range(0, 9) != 0);
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cap_t c1;
    logic [2:0] op;
    logic [1:0] s, d;
    logic [47:0] imm;
    for (int i = 0; i < 4; i++) begin rf[i] = '0; ref_rf[i] = '0; end

    repeat (3) @(negedge iw_clk);
    chk("rst_ready", 64'(ow_req_ready), 64'd1);
    chk("rst_done", 64'(ow_done), 64'd0);
    chk("rst_fault", 64'(ow_fault), 64'd0);
    chk("rst_rd_addr", 64'(ow_rd_addr), 64'd0);
    chk("rst_wr_data", 64'(ow_wr_base | ow_wr_len | ow_wr_cur), 64'd0);
    chk("rst_wr_en", 64'({ow_wr_en_tag, ow_wr_en_attr, ow_wr_en_perms, ow_wr_en_cur,
                          ow_wr_en_len, ow_wr_en_base}), 64'd0);
    iw_rst = 1'b0;
    @(negedge iw_clk);

    c1 = mk_cap(48'h1000, 48'h100, 48'h1010, 24'h0, 1'b1);
    preload(2'd1, c1);
    issue(3'd0, 2'd1, 2'd2, 48'h0, 1'b0);
    chk("busy_n1", 64'(ow_req_ready), 64'd0);
    @(negedge iw_clk);
    chk("busy_n2", 64'(ow_req_ready), 64'd0);
    @(negedge iw_clk);
    chk("busy_n3", 64'(ow_req_ready), 64'd0);
    chk("done_n3", 64'(ow_done), 64'd1);
    @(negedge iw_clk);
    chk("ready_n4", 64'(ow_req_ready), 64'd1);
    drain();
    chk_cap("cmov_cr2", rf[2], c1);
    chk("cmov_en", 64'(last_en), 64'h3F);

    issue(3'd2, 2'd1, 2'd3, 48'hF0, 1'b0); drain();
    chk("csetb_base", 64'(rf[3].base), 64'h1010);
    chk("csetb_cur", 64'(rf[3].cur), 64'h1010);
    chk("csetb_len", 64'(rf[3].len), 64'hF0);
    chk("csetb_fault", 64'(last_fault), 64'd0);
    issue(3'd2, 2'd1, 2'd0, 48'hF1, 1'b0); drain();
    chk("csetb_bounds", 64'(last_fault), 64'd3);
    chk("csetb_bounds_en", 64'(last_en), 64'd0);

    preload(2'd1, mk_cap(48'h1000, 48'h100, 48'hFFFF_FFFF_FFFF, 24'h0, 1'b1));
    issue(3'd1, 2'd1, 2'd2, 48'd2, 1'b0); drain();
    chk("cinc_wrap", 64'(rf[2].cur), 64'h1);
    chk("cinc_fault", 64'(last_fault), 64'd0);
    preload(2'd1, mk_cap(48'h1000, 48'h100, 48'h1010, 24'h1, 1'b1));
    issue(3'd1, 2'd1, 2'd2, 48'd2, 1'b0); drain();
    chk("cinc_sealed", 64'(last_fault), 64'd2);

    preload(2'd1, c1);
    issue(3'd4, 2'd1, 2'd2, 48'hAB, 1'b0); drain();
    chk("cseal_attr", 64'(rf[2].attr), 64'hAB01);
    issue(3'd5, 2'd2, 2'd3, 48'hAB, 1'b0); drain();
    chk("cunseal_attr", 64'(rf[3].attr), 64'h0);
    issue(3'd5, 2'd2, 2'd0, 48'hAC, 1'b0); drain();
    chk("cunseal_otype", 64'(last_fault), 64'd4);

    preload(2'd1, mk_cap(48'h1000, 48'h100, 48'h1010, 24'h0, 1'b0));
    issue(3'd3, 2'd1, 2'd0, 48'hFF, 1'b0); drain();
    chk("candp_untagged", 64'(last_fault), 64'd1);
    issue(3'd6, 2'd1, 2'd1, 48'h0, 1'b0); drain();
    chk("cclrtag_fault", 64'(last_fault), 64'd0);
    chk("cclrtag_en", 64'(last_en), 64'h20);
    issue(3'd7, 2'd2, 2'd0, 48'h0, 1'b0); drain();
    chk("illegal", 64'(last_fault), 64'd5);

    preload(2'd1, c1);
    iw_req_valid = 1'b1; iw_op = 3'd0; iw_src_cr = 2'd1; iw_dst_cr = 2'd0;
    @(negedge iw_clk);
    iw_req_valid = 1'b0;
    @(negedge iw_clk);
    iw_rst = 1'b1;
    #1;
    chk("abort_done", 64'(ow_done), 64'd0);
    @(negedge iw_clk);
    iw_rst = 1'b0;
    chk("abort_ready", 64'(ow_req_ready), 64'd1);
    repeat (5) @(negedge iw_clk);
    chk_cap("abort_no_write", rf[0], ref_rf[0]);
    issue(3'd0, 2'd1, 2'd3, 48'h0, 1'b0); drain();
    chk("post_abort_fault", 64'(last_fault), 64'd0);
    chk_cap("post_abort_cr3", rf[3], c1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drain();
        preload(2'($urandom_range(0, 3)), rand_cap());
      end
      op = 3'($urandom_range(0, 7));
      s = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: imm = 48'($urandom_range(0, 512));
        1: imm = {32'h0, ref_rf[s].attr[23:8]};
        default: imm = {16'($urandom), 32'($urandom)};
      endcase
      issue(op, s, d, imm, ($urandom_range(0, 1) == 1));
    end
    drain();
    for (int i = 0; i < 4; i++) chk_cap($sformatf("final_cr%0d", i), rf[i], ref_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
